// File: rtl/dma_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_priority_arbiter_if
// Description : Request/grant bundle between the DMA register file, the
//               arbiter and the transfer-timing FSM. The master modport is
//               the arbiter side; the slave modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_priority_arbiter_if;
  logic [3:0] DREQ;
  logic [7:0] commandReg;
  logic [7:0] requestReg;
  logic [7:0] maskReg;
  logic       HLDA;
  logic       serviceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChan;

  modport master (
    input  DREQ, commandReg, requestReg, maskReg, HLDA, serviceDone,
    output HRQ, DACK, grantValid, grantChan
  );

  modport slave (
    output DREQ, commandReg, requestReg, maskReg, HLDA, serviceDone,
    input  HRQ, DACK, grantValid, grantChan
  );
endinterface
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_priority_arbiter
// Description : 4-channel DMA request arbiter and HRQ/HLDA bus-hold sequencer
//               with fixed or rotating priority and programmable DREQ/DACK
//               polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_priority_arbiter (
  input  wire                          CLK,
  input  wire                          RESET,
  dma_priority_arbiter_if.master       bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic [1:0] r_grantChan;
  logic [1:0] w_grantChanNext;
  logic [1:0] r_lastServed;
  logic [1:0] w_lastServedNext;

  logic [3:0] w_pending;
  logic       w_reqAny;
  logic [1:0] w_winner;
  logic [1:0] w_start;
  logic [1:0] w_idx;
  logic       w_found;
  logic [3:0] w_ack;

  // Register bits that belong to other parts of the controller.
  logic w_unused;
  assign w_unused = &{1'b0, bus.commandReg[5], bus.commandReg[3],
                      bus.commandReg[1:0], bus.requestReg[7:4],
                      bus.maskReg[7:4]};

  // Effective per-channel request after DREQ sense, software request and mask.
  assign w_pending = ((bus.DREQ ^ {4{bus.commandReg[6]}}) | bus.requestReg[3:0])
                     & ~bus.maskReg[3:0];
  assign w_reqAny  = (|w_pending) & ~bus.commandReg[2];

  // Circular search from the highest-priority slot; fixed mode starts at 0.
  always_comb begin
    w_winner = 2'd0;
    w_found  = 1'b0;
    w_idx    = 2'd0;
    w_start  = bus.commandReg[4] ? (r_lastServed + 2'd1) : 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_start + k[1:0];
      if (!w_found && w_pending[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  // State, grant latch and rotation pointer; reset is immediate.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_grantChan  <= 2'd0;
      r_lastServed <= 2'd3;
    end else begin
      r_state      <= w_stateNext;
      r_grantChan  <= w_grantChanNext;
      r_lastServed <= w_lastServedNext;
    end
  end

  // Next-state logic; the winner is latched once on HLDA and then frozen.
  always_comb begin
    w_stateNext      = r_state;
    w_grantChanNext  = r_grantChan;
    w_lastServedNext = r_lastServed;
    case (r_state)
      ST_IDLE: begin
        if (w_reqAny) w_stateNext = ST_REQ;
      end
      ST_REQ: begin
        if (!w_reqAny) begin
          w_stateNext = ST_IDLE;
        end else if (bus.HLDA) begin
          w_stateNext     = ST_GRANT;
          w_grantChanNext = w_winner;
        end
      end
      ST_GRANT: begin
        // serviceDone takes precedence over a simultaneous loss of HLDA.
        if (bus.serviceDone) begin
          w_stateNext      = ST_RELEASE;
          w_lastServedNext = r_grantChan;
        end else if (!bus.HLDA) begin
          w_stateNext = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign w_ack          = (r_state == ST_GRANT) ? (4'b0001 << r_grantChan) : 4'b0000;
  assign bus.HRQ        = (r_state == ST_REQ) || (r_state == ST_GRANT);
  assign bus.grantValid = (r_state == ST_GRANT);
  assign bus.grantChan  = r_grantChan;
  // DACK polarity tracks commandReg[7] combinationally.
  assign bus.DACK       = w_ack ^ {4{~bus.commandReg[7]}};

endmodule
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_priority_arbiter
// Description : Directed self-checking bench for dma_priority_arbiter.
//               Expected status words {HRQ, grantValid, grantChan, DACK} are
//               queued as stimulus is applied and popped when sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_priority_arbiter;

  logic CLK;
  logic RESET;

  dma_priority_arbiter_if bus ();

  dma_priority_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   order[7] = '{0, 1, 2, 3, 0, 1, 2};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Upper bound on run time in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] st(input logic hrq, input logic gv,
                                    input logic [1:0] gc, input logic [3:0] dack);
    return {hrq, gv, gc, dack};
  endfunction

  // Active-low DACK pattern for a granted channel.
  function automatic logic [3:0] dl(input int c);
    logic [3:0] oh;
    oh = 4'b0001 << c;
    return ~oh;
  endfunction

  function automatic logic [7:0] obs();
    return {bus.HRQ, bus.grantValid, bus.grantChan, bus.DACK};
  endfunction

  task automatic exp_push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    expQ.push_back(e);
  endtask

  task automatic exp_check(input logic [7:0] o);
    exp_t e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", o);
    end else begin
      e = expQ.pop_front();
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic service();
    bus.serviceDone = 1'b1;
    step();
    bus.serviceDone = 1'b0;
  endtask

  initial begin
    RESET              = 1'b1;
    bus.DREQ           = 4'b0000;
    bus.commandReg     = 8'h00;
    bus.requestReg     = 8'h00;
    bus.maskReg        = 8'h00;
    bus.HLDA           = 1'b0;
    bus.serviceDone    = 1'b0;
    #1;
    exp_push("reset", st(0, 0, 2'd0, 4'hF));
    exp_check(obs());
    step();
    RESET = 1'b0;
    step();

    // ---- fixed priority ----
    bus.DREQ = 4'b1010;
    exp_push("fix_req", st(1, 0, 2'd0, 4'hF));
    step(); exp_check(obs());
    exp_push("fix_wait", st(1, 0, 2'd0, 4'hF));
    step(); exp_check(obs());
    bus.HLDA = 1'b1;
    exp_push("fix_grant1", st(1, 1, 2'd1, 4'b1101));
    step(); exp_check(obs());
    bus.DREQ = 4'b1000;
    exp_push("fix_release", st(0, 0, 2'd1, 4'hF));
    service(); exp_check(obs());
    exp_push("fix_idle_gap", st(0, 0, 2'd1, 4'hF));
    step(); exp_check(obs());
    exp_push("fix_rereq", st(1, 0, 2'd1, 4'hF));
    step(); exp_check(obs());
    exp_push("fix_grant3", st(1, 1, 2'd3, 4'b0111));
    step(); exp_check(obs());
    bus.DREQ = 4'b0000;
    exp_push("fix_release3", st(0, 0, 2'd3, 4'hF));
    service(); exp_check(obs());
    step();

    // ---- rotating priority, all channels requesting ----
    bus.commandReg = 8'h10;
    bus.DREQ       = 4'b1111;
    exp_push("rot_req", st(1, 0, 2'd3, 4'hF));
    step(); exp_check(obs());
    exp_push("rot_grant_first", st(1, 1, 2'd0, dl(0)));
    step(); exp_check(obs());
    for (int i = 1; i < 7; i++) begin
      exp_push("rot_release", st(0, 0, 2'(order[i-1]), 4'hF));
      service(); exp_check(obs());
      step(); step();
      exp_push("rot_grant", st(1, 1, 2'(order[i]), dl(order[i])));
      step(); exp_check(obs());
    end
    // Bus lost on channel 2: no rotation, channel 2 served again.
    bus.HLDA = 1'b0;
    exp_push("rot_hlda_drop", st(0, 0, 2'd2, 4'hF));
    step(); exp_check(obs());
    bus.HLDA = 1'b1;
    exp_push("rot_rereq", st(1, 0, 2'd2, 4'hF));
    step(); exp_check(obs());
    exp_push("rot_regrant2", st(1, 1, 2'd2, dl(2)));
    step(); exp_check(obs());
    bus.DREQ       = 4'b0000;
    bus.HLDA       = 1'b0;
    bus.commandReg = 8'h00;
    exp_push("rot_release2", st(0, 0, 2'd2, 4'hF));
    service(); exp_check(obs());
    step();

    // ---- mask and software request ----
    bus.maskReg = 8'h01;
    bus.DREQ    = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      exp_push("mask_hold", st(0, 0, 2'd2, 4'hF));
      step(); exp_check(obs());
    end
    bus.requestReg = 8'h04;
    exp_push("swreq_req", st(1, 0, 2'd2, 4'hF));
    step(); exp_check(obs());
    bus.HLDA = 1'b1;
    exp_push("swreq_grant", st(1, 1, 2'd2, dl(2)));
    step(); exp_check(obs());
    exp_push("swreq_release", st(0, 0, 2'd2, 4'hF));
    service(); exp_check(obs());
    bus.requestReg = 8'h00;
    bus.maskReg    = 8'h00;
    bus.DREQ       = 4'b0000;
    bus.HLDA       = 1'b0;
    step();

    // ---- polarity ----
    bus.commandReg = 8'hC0;
    bus.DREQ       = 4'b1110;
    exp_push("pol_req", st(1, 0, 2'd2, 4'b0000));
    step(); exp_check(obs());
    bus.HLDA = 1'b1;
    exp_push("pol_grant", st(1, 1, 2'd0, 4'b0001));
    step(); exp_check(obs());
    bus.commandReg = 8'h40;
    #1;
    exp_push("pol_flip", st(1, 1, 2'd0, 4'b1110));
    exp_check(obs());
    bus.DREQ = 4'b1111;
    exp_push("pol_frozen", st(1, 1, 2'd0, 4'b1110));
    step(); exp_check(obs());
    service();
    bus.commandReg = 8'h00;
    bus.DREQ       = 4'b0000;
    bus.HLDA       = 1'b0;
    #1;
    exp_push("pol_release", st(0, 0, 2'd0, 4'hF));
    exp_check(obs());
    step();

    // ---- withdrawal before HLDA ----
    bus.DREQ = 4'b1000;
    exp_push("wd_req", st(1, 0, 2'd0, 4'hF));
    step(); exp_check(obs());
    bus.DREQ = 4'b0000;
    exp_push("wd_drop", st(0, 0, 2'd0, 4'hF));
    step(); exp_check(obs());
    exp_push("wd_idle", st(0, 0, 2'd0, 4'hF));
    step(); exp_check(obs());

    // ---- controller disable ----
    bus.commandReg = 8'h04;
    bus.DREQ       = 4'b1111;
    bus.HLDA       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_push("disable_hold", st(0, 0, 2'd0, 4'hF));
      step(); exp_check(obs());
    end
    bus.commandReg = 8'h00;
    bus.DREQ       = 4'b0000;
    bus.HLDA       = 1'b0;
    step();

    // ---- reset mid-grant, then rotation restarts at channel 0 ----
    bus.commandReg = 8'h10;
    bus.DREQ       = 4'b0011;
    exp_push("rst_req", st(1, 0, 2'd0, 4'hF));
    step(); exp_check(obs());
    bus.HLDA = 1'b1;
    exp_push("rst_grant1", st(1, 1, 2'd1, dl(1)));
    step(); exp_check(obs());
    #2;
    RESET = 1'b1;
    #1;
    exp_push("rst_async", st(0, 0, 2'd0, 4'hF));
    exp_check(obs());
    RESET = 1'b0;
    exp_push("rst_rereq", st(1, 0, 2'd0, 4'hF));
    step(); exp_check(obs());
    exp_push("rst_grant0", st(1, 1, 2'd0, dl(0)));
    step(); exp_check(obs());

    // serviceDone together with HLDA loss still completes and rotates.
    bus.HLDA = 1'b0;
    exp_push("simul_release", st(0, 0, 2'd0, 4'hF));
    service(); exp_check(obs());
    bus.HLDA = 1'b1;
    step();
    exp_push("simul_rereq", st(1, 0, 2'd0, 4'hF));
    step(); exp_check(obs());
    exp_push("simul_grant1", st(1, 1, 2'd1, dl(1)));
    step(); exp_check(obs());
    bus.DREQ = 4'b0000;
    bus.HLDA = 1'b0;
    service();
    step();

    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
